// File: rtl/sim_iddr_deser_if.sv
// Bus bundle for the DDR input deserialiser: DDR data and controls in, aligned
// pair and deserialised word out.
interface sim_iddr_deser_if #(
    parameter int WIDTH = 4,
    parameter int RATIO = 4
);
    logic                     ce;
    logic [WIDTH-1:0]         d;
    logic                     bitslip;
    logic [WIDTH-1:0]         q1;
    logic [WIDTH-1:0]         q2;
    logic [WIDTH*RATIO-1:0]   word;
    logic                     word_valid;

    modport master (output ce, d, bitslip, input q1, q2, word, word_valid);
    modport slave  (input ce, d, bitslip, output q1, q2, word, word_valid);
endinterface

// File: rtl/sim_iddr_deser.sv
// DDR input capture (three alignment modes) feeding a per-lane 2-bit-per-cycle
// shift register with a shared word counter and bitslip control.
module sim_iddr_deser_lane #(
    parameter int MODE  = 2,
    parameter int RATIO = 4
) (
    input  logic             clk100,
    input  logic             reset,
    input  logic             ce,
    input  logic             d,
    input  logic             load,
    output logic             q1,
    output logic             q2,
    output logic [RATIO-1:0] word
);
    logic             rise_s;
    logic             fall_s;
    logic [RATIO-1:0] sr_nxt;

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset)   rise_s <= 1'b0;
        else if (ce) rise_s <= d;
    end

    always_ff @(negedge clk100 or posedge reset) begin
        if (reset)   fall_s <= 1'b0;
        else if (ce) fall_s <= d;
    end

    // Only the low RATIO-2 bits survive the next shift, so only they are stored.
    if (RATIO == 2) begin : g_r2
        assign sr_nxt = {rise_s, fall_s};
    end else begin : g_rn
        logic [RATIO-3:0] hist;
        always_ff @(posedge clk100 or posedge reset) begin
            if (reset)   hist <= '0;
            else if (ce) hist <= sr_nxt[RATIO-3:0];
        end
        assign sr_nxt = {hist, rise_s, fall_s};
    end

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset)           word <= '0;
        else if (ce && load) word <= sr_nxt;
    end

    if (MODE == 2) begin : g_q1_pipe
        always_ff @(posedge clk100 or posedge reset) begin
            if (reset)   q1 <= 1'b0;
            else if (ce) q1 <= rise_s;
        end
    end else begin : g_q1_dir
        assign q1 = rise_s;
    end

    // MODE 0 exposes the falling sample as soon as it is taken.
    if (MODE == 0) begin : g_q2_neg
        assign q2 = fall_s;
    end else begin : g_q2_pos
        always_ff @(posedge clk100 or posedge reset) begin
            if (reset)   q2 <= 1'b0;
            else if (ce) q2 <= fall_s;
        end
    end
endmodule

module sim_iddr_deser #(
    parameter int WIDTH = 4,
    parameter int MODE  = 2,
    parameter int RATIO = 4
) (
    input logic             clk100,
    input logic             reset,
    sim_iddr_deser_if.slave bus
);
    localparam int CW = (RATIO > 2) ? $clog2(RATIO / 2) : 1;
    localparam logic [CW-1:0] LAST = CW'(RATIO / 2 - 1);

    logic [CW-1:0] cnt;
    logic          load;

    // A slipped pair is shifted in but not counted, pushing the boundary 2 bits.
    assign load = bus.ce && !bus.bitslip && (cnt == LAST);

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            cnt             <= '0;
            bus.word_valid  <= 1'b0;
        end else begin
            bus.word_valid <= load;
            if (bus.ce && !bus.bitslip)
                cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    for (genvar l = 0; l < WIDTH; l++) begin : g_lane
        sim_iddr_deser_lane #(.MODE(MODE), .RATIO(RATIO)) u_lane (
            .clk100 (clk100),
            .reset  (reset),
            .ce     (bus.ce),
            .d      (bus.d[l]),
            .load   (load),
            .q1     (bus.q1[l]),
            .q2     (bus.q2[l]),
            .word   (bus.word[l*RATIO +: RATIO])
        );
    end
endmodule

// File: tb/tb_sim_iddr_deser.sv
// Randomised bench: three MODE variants share one stimulus and are compared
// against a bit-history reference model.
module tb_sim_iddr_deser;
    localparam int W = 4;
    localparam int R = 4;

    logic clk100 = 1'b0;
    logic reset;
    logic ce, bitslip;
    logic [W-1:0] d;
    int n_chk = 0;
    int n_err = 0;

    always #5 clk100 = ~clk100;

    sim_iddr_deser_if #(.WIDTH(W), .RATIO(R)) b0 ();
    sim_iddr_deser_if #(.WIDTH(W), .RATIO(R)) b1 ();
    sim_iddr_deser_if #(.WIDTH(W), .RATIO(R)) b2 ();
    assign b0.ce = ce; assign b0.d = d; assign b0.bitslip = bitslip;
    assign b1.ce = ce; assign b1.d = d; assign b1.bitslip = bitslip;
    assign b2.ce = ce; assign b2.d = d; assign b2.bitslip = bitslip;

    sim_iddr_deser #(.WIDTH(W), .MODE(0), .RATIO(R)) u_m0 (.clk100(clk100), .reset(reset), .bus(b0.slave));
    sim_iddr_deser #(.WIDTH(W), .MODE(1), .RATIO(R)) u_m1 (.clk100(clk100), .reset(reset), .bus(b1.slave));
    sim_iddr_deser #(.WIDTH(W), .MODE(2), .RATIO(R)) u_m2 (.clk100(clk100), .reset(reset), .bus(b2.slave));

    // Reference model: held edge samples, full consumed-bit history, counted pairs.
    logic [W-1:0]   m_rise, m_fall;
    logic [W-1:0]   eq1 [3];
    logic [W-1:0]   eq2 [3];
    logic [W*R-1:0] m_word;
    logic           m_vld;
    int             counted;
    logic [W-1:0]   hist_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rise = '0; m_fall = '0; m_word = '0; m_vld = 1'b0; counted = 0;
        for (int m = 0; m < 3; m++) begin eq1[m] = '0; eq2[m] = '0; end
        hist_q.delete();
    endtask

    task automatic pos_step();
        if (!ce) begin
            m_vld = 1'b0;
            return;
        end
        hist_q.push_back(m_rise);
        hist_q.push_back(m_fall);
        while (hist_q.size() > R) void'(hist_q.pop_front());
        m_vld = 1'b0;
        if (!bitslip) begin
            counted++;
            if (counted % (R / 2) == 0) begin
                m_vld = 1'b1;
                for (int l = 0; l < W; l++)
                    for (int k = 0; k < R; k++) begin
                        int idx = hist_q.size() - R + k;
                        m_word[l*R + R-1-k] = (idx >= 0) ? hist_q[idx][l] : 1'b0;
                    end
            end
        end
        eq1[2] = m_rise; eq2[2] = m_fall;
        eq1[1] = d;      eq2[1] = m_fall;
        eq1[0] = d;
        m_rise = d;
    endtask

    task automatic neg_step();
        if (ce) begin
            m_fall = d;
            eq2[0] = d;
        end
    endtask

    task automatic check_all();
        chk("m0_q1", 32'(b0.q1), 32'(eq1[0]));
        chk("m0_q2", 32'(b0.q2), 32'(eq2[0]));
        chk("m1_q1", 32'(b1.q1), 32'(eq1[1]));
        chk("m1_q2", 32'(b1.q2), 32'(eq2[1]));
        chk("m2_q1", 32'(b2.q1), 32'(eq1[2]));
        chk("m2_q2", 32'(b2.q2), 32'(eq2[2]));
        chk("m0_word", 32'(b0.word), 32'(m_word));
        chk("m1_word", 32'(b1.word), 32'(m_word));
        chk("m2_word", 32'(b2.word), 32'(m_word));
        chk("m0_vld", 32'(b0.word_valid), 32'(m_vld));
        chk("m1_vld", 32'(b1.word_valid), 32'(m_vld));
        chk("m2_vld", 32'(b2.word_valid), 32'(m_vld));
    endtask

    // One clock: posedge inputs, then negedge inputs; entered and left just after a negedge.
    task automatic cyc(input logic cp, input logic bs, input logic [W-1:0] dp,
                       input logic cn, input logic [W-1:0] dn);
        ce = cp; bitslip = bs; d = dp;
        @(posedge clk100);
        if (!reset) pos_step();
        #1 check_all();
        ce = cn; bitslip = 1'b0; d = dn;
        @(negedge clk100);
        if (!reset) neg_step();
        #1 check_all();
    endtask

    task automatic rnd_cyc();
        cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0), W'($urandom),
            ($urandom_range(0, 9) != 0), W'($urandom));
    endtask

    initial begin
        logic [7:0] pat [W];
        logic [W-1:0] dr, df;
        reset = 1'b1; ce = 1'b0; bitslip = 1'b0; d = '0;
        model_reset();
        #12 check_all();
        @(negedge clk100);
        #1 reset = 1'b0;

        // half-cycle sequence 1,0,1,1 then idle
        cyc(1'b1, 1'b0, '1, 1'b1, '0);
        cyc(1'b1, 1'b0, '1, 1'b1, '1);
        cyc(1'b1, 1'b0, '0, 1'b1, '0);
        cyc(1'b1, 1'b0, '0, 1'b1, '0);
        // rise=1 / fall=0 toggling
        repeat (6) cyc(1'b1, 1'b0, '1, 1'b1, '0);
        // ce low for 3 posedges mid-word, bitslip during ce=0 must be ignored
        cyc(1'b1, 1'b0, 4'hA, 1'b1, 4'h5);
        cyc(1'b0, 1'b1, 4'h3, 1'b0, 4'hC);
        cyc(1'b0, 1'b0, 4'h6, 1'b0, 4'h9);
        cyc(1'b0, 1'b1, 4'hF, 1'b0, 4'h0);
        repeat (4) cyc(1'b1, 1'b0, 4'h2, 1'b1, 4'hD);

        // repeating 1100_1010 per lane (rotated per lane), one bitslip, then back-to-back slips
        for (int l = 0; l < W; l++) begin
            logic [15:0] dbl;
            dbl = {8'hCA, 8'hCA} << (2 * l);
            pat[l] = dbl[15:8];
        end
        for (int i = 0; i < 32; i++) begin
            for (int l = 0; l < W; l++) begin
                dr[l] = pat[l][7 - 2*(i % 4)];
                df[l] = pat[l][6 - 2*(i % 4)];
            end
            cyc(1'b1, (i == 9 || i == 20 || i == 21), dr, 1'b1, df);
        end

        repeat (300) rnd_cyc();

        // reset between negedge and posedge, mid-word
        cyc(1'b1, 1'b0, 4'h7, 1'b1, 4'hB);
        #2 reset = 1'b1;
        #1 model_reset();
        check_all();
        cyc(1'b1, 1'b0, '1, 1'b1, '1);
        reset = 1'b0;
        repeat (6) cyc(1'b1, 1'b0, W'($urandom), 1'b1, W'($urandom));

        repeat (200) rnd_cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/sim_iddr_deser.md
SIM_IDDR_DESER -- requirements
Module: sim_iddr_deser

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, number of independent DDR input lanes (1..16).
REQ-002 The block SHALL have parameter MODE, default 2, capture alignment: 0 OPPOSITE_EDGE, 1 SAME_EDGE, 2 SAME_EDGE_PIPELINED.
REQ-003 The block SHALL have parameter RATIO, default 4, deserialised bits per lane per word (even, 2..8).
REQ-004 The block SHALL have port clk100  input  1  capture clock; both edges used.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port ce  input  1  clock enable, sampled on both edges.
REQ-007 The block SHALL have port d  input  WIDTH  DDR data, one bit per lane.
REQ-008 The block SHALL have port bitslip  input  1  single-cycle word-alignment request, sampled at posedge.
REQ-009 The block SHALL have port q1  output  WIDTH  rising-edge data per lane.
REQ-010 The block SHALL have port q2  output  WIDTH  falling-edge data per lane.
REQ-011 The block SHALL have port word  output  WIDTH*RATIO  deserialised word; lane l in word[l*RATIO +: RATIO].
REQ-012 The block SHALL have port word_valid  output  1  one-cycle strobe, word updated.

Function
REQ-013 Edge sampling: rise(N) = d at posedge N; fall(N) = d at the negedge following posedge N; a sample is taken only if ce=1 at that edge, else the previous sample is held.
REQ-014 MODE 0: q1 <= rise(N) at posedge N; q2 <= fall(N) at the negedge after posedge N.
REQ-015 MODE 1: at posedge N, q1 <= rise(N), q2 <= fall(N-1).
REQ-016 MODE 2: at posedge N, q1 <= rise(N-1), q2 <= fall(N-1); q1/q2 form an aligned pair, one posedge latency.
REQ-017 With ce=0 at a posedge, q1, q2, shift register, pair counter, word and word_valid (forced 0) SHALL hold.
REQ-018 Deserialiser SHALL consume the aligned pair (rise(N-1), fall(N-1)) at each ce posedge N, independent of MODE.
REQ-019 Per lane, a RATIO-bit shift register SHALL shift left by 2, inserting rise then fall; earliest bit ends at MSB.
REQ-020 Pair counter cnt (0..RATIO/2-1) SHALL increment per consumed pair and wrap to 0 after RATIO/2-1.
REQ-021 When a pair is consumed with cnt=RATIO/2-1 and bitslip=0, word SHALL load the shift register including that pair, and word_valid SHALL be 1 for exactly that cycle.
REQ-022 bitslip=1 at a ce posedge: pair still shifted, cnt held (not incremented), no word emitted; word boundary moves 2 bits later.
REQ-023 bitslip=1 with ce=0 SHALL be ignored; back-to-back bitslip pulses SHALL each slip one pair.
REQ-024 bitslip coincident with cnt=RATIO/2-1 SHALL suppress that word_valid; the next word is emitted one pair later.
REQ-025 All lanes SHALL share cnt, bitslip and word_valid; word_valid SHALL never be high on two consecutive posedges when RATIO>2.

Reset
REQ-026 reset=1 SHALL asynchronously clear q1, q2, word, word_valid, cnt, shift registers and internal edge samples to 0.
REQ-027 While reset=1, all edges SHALL be ignored; after deassertion the first word_valid SHALL occur no earlier than the RATIO/2-th ce posedge.
REQ-028 Reset asserted mid-word SHALL discard the partial word; no word_valid for it.

Verification
REQ-029 WIDTH=1, MODE=2, RATIO=4, d half-cycle sequence 1,0,1,1 from a posedge -> q1/q2 = 1/0 then 1/1 on successive posedges; word=4'b1011 with one word_valid pulse.
REQ-030 MODE=0 vs MODE=1 with d toggling every half-cycle (rise=1, fall=0) -> MODE0: q2 updates at negedge; MODE1: q1=1, q2=0 both changing only at posedge.
REQ-031 ce=0 for 3 posedges mid-word, RATIO=4 -> q1, q2, word frozen, no word_valid; word resumes correctly on ce=1 with no lost or duplicated pair.
REQ-032 Repeating 8-bit pattern 8'b1100_1010, RATIO=4, one bitslip pulse -> word sequence changes from 1100,1010 to 0010,1011 (shifted 2 bits), one word_valid suppressed.
REQ-033 reset asserted between negedge and posedge mid-word -> all outputs 0 immediately; first word_valid exactly 2 ce posedges after release plus pipeline edge.
REQ-034 WIDTH=4, distinct per-lane patterns -> each lane's bits appear in its own word slice, no cross-lane mixing.
